// File: rtl/instr_fetch.sv
// Instruction fetch: registered PC with branch, halt and advance counter.
// Define INSTR_FETCH_RELBR_EN for PC-relative branch targets.
module instr_fetch #(
  parameter int IW         = 8,
  parameter int START_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branchsig,
  input  logic          branchtype,
  input  logic [7:0]    BranchOut,
  input  logic [7:0]    cmp,
  input  logic          halt,
  output logic [IW-1:0] core,
  output logic          taken,
  output logic          halted,
  output logic [15:0]   icount
);

  localparam logic [IW-1:0] START = IW'(START_ADDR);

  logic [IW-1:0] target;
  logic [IW-1:0] next_pc;

  always_comb begin
    taken = branchsig & ~halt & (~branchtype | (|cmp));
  end

`ifdef INSTR_FETCH_RELBR_EN
  // offset is signed; the sum wraps modulo 2^IW
  always_comb begin
    target = core + IW'($signed(BranchOut));
  end
`else
  always_comb begin
    target = IW'(BranchOut);
  end
`endif

  always_comb begin
    next_pc = taken ? target : core + IW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core   <= START;
      halted <= 1'b0;
      icount <= 16'h0000;
    end else if (halt) begin
      halted <= 1'b1;
    end else begin
      core <= next_pc;
      if (icount != 16'hFFFF)
        icount <= icount + 16'h0001;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised self-checking bench for instr_fetch with a PC reference model.
module tb_instr_fetch;

  localparam int IW = 8;
  localparam int START_ADDR = 0;
  localparam int MOD = 1 << IW;

  logic          clk = 1'b0;
  logic          reset;
  logic          branchsig;
  logic          branchtype;
  logic [7:0]    BranchOut;
  logic [7:0]    cmp;
  logic          halt;
  logic [IW-1:0] core;
  logic          taken;
  logic          halted;
  logic [15:0]   icount;

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_cnt;
  bit m_halted;

  instr_fetch #(.IW(IW), .START_ADDR(START_ADDR)) dut (
    .clk(clk),
    .reset(reset),
    .branchsig(branchsig),
    .branchtype(branchtype),
    .BranchOut(BranchOut),
    .cmp(cmp),
    .halt(halt),
    .core(core),
    .taken(taken),
    .halted(halted),
    .icount(icount)
  );

  always #5 clk = ~clk;

  function automatic bit exp_taken();
    return branchsig && !halt && (!branchtype || cmp != 8'h00);
  endfunction

  function automatic int branch_target(int pc, int bo);
`ifdef INSTR_FETCH_RELBR_EN
    int off;
    off = (bo >= 128) ? bo - 256 : bo;
    return ((pc + off) % MOD + MOD) % MOD;
`else
    return bo % MOD;
`endif
  endfunction

  function automatic int bo_for(int dest);
`ifdef INSTR_FETCH_RELBR_EN
    return ((dest - m_pc) % 256 + 256) % 256;
`else
    return dest;
`endif
  endfunction

  task automatic model_reset();
    m_pc = START_ADDR % MOD;
    m_cnt = 0;
    m_halted = 1'b0;
  endtask

  task automatic drive(bit bs, bit bt, int bo, int c, bit h);
    branchsig = bs;
    branchtype = bt;
    BranchOut = 8'(bo);
    cmp = 8'(c);
    halt = h;
  endtask

  // advance one clock and the reference model with it
  task automatic tick();
    bit t;
    int tgt;
    t = exp_taken();
    tgt = branch_target(m_pc, int'(BranchOut));
    @(posedge clk);
    if (halt) begin
      m_halted = 1'b1;
    end else begin
      m_pc = t ? tgt : (m_pc + 1) % MOD;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic goto_pc(int dest);
    drive(1, 0, bo_for(dest), 0, 0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2;
    checks++;
    if (core !== IW'(START_ADDR) || icount !== 16'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: core=%h icount=%h halted=%b required %h/0/0",
               core, icount, halted, IW'(START_ADDR));
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_pc = (m_pc + 1) % MOD;
    m_cnt = 1;
    checks++;
    if (core !== IW'(m_pc)) begin
      errors++;
      $display("FAIL reset_first_edge: core=%h required %h", core, m_pc);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (core !== IW'(i)) begin
        errors++;
        $display("FAIL seq_core%0d: core=%h required %h", i, core, i);
      end
    end
    checks++;
    if (icount !== 16'd5 || halted !== 1'b0 || m_cnt != 5) begin
      errors++;
      $display("FAIL seq_count: icount=%0d halted=%b required 5/0", icount, halted);
    end
  endtask

  task automatic test_uncond_branch();
    goto_pc('h10);
    drive(1, 0, 'h2A, 0, 0);
    #1;
    checks++;
    if (taken !== 1'b1) begin
      errors++;
      $display("FAIL uncond_taken: taken=%b required 1", taken);
    end
    tick();
    checks++;
`ifdef INSTR_FETCH_RELBR_EN
    if (core !== 8'h3A) begin
      errors++;
      $display("FAIL uncond_target: core=%h required 3a", core);
    end
`else
    if (core !== 8'h2A) begin
      errors++;
      $display("FAIL uncond_target: core=%h required 2a", core);
    end
`endif
  endtask

  task automatic test_cond_branch();
    goto_pc('h20);
    drive(1, 1, 'h05, 'h00, 0);
    #1;
    checks++;
    if (taken !== 1'b0) begin
      errors++;
      $display("FAIL cond_nt_taken: taken=%b required 0", taken);
    end
    tick();
    checks++;
    if (core !== 8'h21) begin
      errors++;
      $display("FAIL cond_nt_core: core=%h required 21", core);
    end
    goto_pc('h20);
    drive(1, 1, 'h05, 'h01, 0);
    #1;
    checks++;
    if (taken !== 1'b1) begin
      errors++;
      $display("FAIL cond_t_taken: taken=%b required 1", taken);
    end
    tick();
    checks++;
`ifdef INSTR_FETCH_RELBR_EN
    if (core !== 8'h25) begin
      errors++;
      $display("FAIL cond_t_core: core=%h required 25", core);
    end
`else
    if (core !== 8'h05) begin
      errors++;
      $display("FAIL cond_t_core: core=%h required 05", core);
    end
`endif
  endtask

  task automatic test_halt();
    int cnt0;
    goto_pc('h30);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 'h77, 'h01, 1);
      #1;
      checks++;
      if (taken !== 1'b0) begin
        errors++;
        $display("FAIL halt_taken%0d: taken=%b required 0", i, taken);
      end
      tick();
      checks++;
      if (core !== 8'h30 || halted !== 1'b1 || icount !== 16'(cnt0)) begin
        errors++;
        $display("FAIL halt_hold%0d: core=%h halted=%b icount=%0d required 30/1/%0d",
                 i, core, halted, icount, cnt0);
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++;
    if (core !== 8'h31 || halted !== 1'b1 || icount !== 16'(cnt0 + 1)) begin
      errors++;
      $display("FAIL halt_resume: core=%h halted=%b icount=%0d required 31/1/%0d",
               core, halted, icount, cnt0 + 1);
    end
  endtask

  task automatic test_wrap_async_reset();
    goto_pc('hFF);
    drive(0, 0, 0, 0, 0);
    tick();
    checks++;
    if (core !== 8'h00) begin
      errors++;
      $display("FAIL wrap: core=%h required 00", core);
    end
    tick();
    tick();
    drive(1, 0, 'h55, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (core !== IW'(START_ADDR) || icount !== 16'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: core=%h icount=%h halted=%b required %h/0/0",
               core, icount, halted, IW'(START_ADDR));
    end
    @(posedge clk);
    #1;
    checks++;
    if (core !== IW'(START_ADDR) || icount !== 16'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: core=%h icount=%h halted=%b required %h/0/0",
               core, icount, halted, IW'(START_ADDR));
    end
    drive(1, 0, bo_for('h44), 0, 0);
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (core !== IW'(m_pc) || icount !== 16'd1) begin
      errors++;
      $display("FAIL reset_release: core=%h icount=%0d required %h/1", core, icount, m_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 255)),
            $urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (taken !== exp_taken()) begin
        errors++;
        $display("FAIL rand_taken%0d: taken=%b required %b", i, taken, exp_taken());
      end
      tick();
      checks++;
      if (core !== IW'(m_pc) || icount !== 16'(m_cnt) || halted !== m_halted) begin
        errors++;
        $display("FAIL rand_state%0d: core=%h icount=%0d halted=%b required %h/%0d/%b",
                 i, core, icount, halted, m_pc, m_cnt, m_halted);
      end
    end
  endtask

  task automatic test_saturate();
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) tick();
    checks++;
    if (icount !== 16'hFFFF || m_cnt != 65535 || core !== IW'(m_pc)) begin
      errors++;
      $display("FAIL saturate: icount=%h core=%h required ffff/%h", icount, core, m_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_uncond_branch();
    test_cond_branch();
    test_halt();
    test_wrap_async_reset();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IW, default 8, program-counter width in bits (legal 4..16).
REQ-002 Parameter START_ADDR, default 0, PC value loaded by reset (truncated to IW bits).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 branchsig  input  1  current instruction is a branch.
REQ-006 branchtype  input  1  0 = unconditional branch, 1 = conditional branch.
REQ-007 BranchOut  input  8  branch target (absolute) or offset (see Configuration), from branch LUT.
REQ-008 cmp  input  8  compare-result register from ALU; nonzero = condition true.
REQ-009 halt  input  1  current instruction is HALT; freezes fetch.
REQ-010 core  output  IW  registered program counter, drives instruction ROM address.
REQ-011 taken  output  1  combinational, branch taken this cycle.
REQ-012 halted  output  1  registered sticky flag, fetch has halted.
REQ-013 icount  output  16  registered count of PC advances since reset.

Function
REQ-014 taken SHALL equal branchsig AND NOT halt AND (NOT branchtype OR cmp != 8'h00).
REQ-015 When branchsig = 0, branchtype, cmp and BranchOut SHALL have no effect.
REQ-016 Next-PC priority SHALL be: reset > halt > taken branch > sequential.
REQ-017 halt = 1 at a rising edge SHALL hold core unchanged, even when branchsig = 1.
REQ-018 taken = 1 at a rising edge SHALL load core with the branch target (REQ-027/028).
REQ-019 Otherwise core SHALL load core + 1 modulo 2^IW (max value wraps to 0).
REQ-020 Latency: the new PC SHALL appear on core one clock after the controlling inputs are sampled; no bubbles or stalls other than halt.
REQ-021 halted SHALL be set at the first rising edge where halt = 1 and remain 1 until reset, even if halt later deasserts.
REQ-022 The PC SHALL resume advancing when halt deasserts; halted does not gate the PC.
REQ-023 icount SHALL increment by 1 at every rising edge where core is updated (halt = 0) and saturate at 16'hFFFF.
REQ-024 Target widths: BranchOut wider than IW SHALL be truncated to its low IW bits; narrower zero-extended (absolute mode).

Reset
REQ-025 reset = 1 SHALL immediately, without waiting for clk, force core = START_ADDR, halted = 0, icount = 0.
REQ-026 While reset = 1, rising clock edges SHALL NOT change state; assertion mid-branch or mid-halt SHALL discard the pending update; the first edge after deassertion SHALL follow normal rules from START_ADDR.

Configuration
REQ-027 Without macro INSTR_FETCH_RELBR_EN, branch target SHALL be absolute: core <= BranchOut per REQ-024.
REQ-028 With INSTR_FETCH_RELBR_EN defined, branch target SHALL be core + sign-extended BranchOut modulo 2^IW (PC-relative, offset range -128..+127); all other behaviour identical.

Verification
REQ-029 Reset then 5 clocks with all control inputs 0 -> core = 0,1,2,3,4,5; icount = 5; halted = 0.
REQ-030 core = 8'h10, branchsig = 1, branchtype = 0, BranchOut = 8'h2A -> taken = 1, next core = 8'h2A (relative build: 8'h3A).
REQ-031 core = 8'h20, branchsig = 1, branchtype = 1, BranchOut = 8'h05: cmp = 8'h00 -> core = 8'h21, taken = 0; cmp = 8'h01 -> core = 8'h05 (relative build: 8'h25).
REQ-032 core = 8'h30, halt = 1 with branchsig = 1 for 3 clocks -> core stays 8'h30, taken = 0, halted = 1, icount unchanged; halt = 0 -> core = 8'h31, halted stays 1.
REQ-033 core = 8'hFF, no branch -> core = 8'h00; reset asserted between clock edges -> core = START_ADDR immediately and icount = 0 before next edge.
